digital_input_capture: RTL and testbench

//   Read-side companion to the bidirectional digital output port. Samples up to WIDTH

---
 rtl/digital_input_capture.sv | 92 +++++++++
 tb/tb_digital_input_capture.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/digital_input_capture.sv
// Synchronised digital input port: per-bit edge detection with enables, sticky
// write-1-to-clear status and a level interrupt, on a chip-select peripheral bus.
module digital_input_capture #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             chipSelect,
  input  logic [1:0]       address,
  input  logic             writeEnable,
  input  logic [31:0]      dataIn,
  output logic [31:0]      dataOut,
  input  logic [WIDTH-1:0] IO_IN,
  output logic             irq
);

  localparam logic [1:0] ADDR_PIN     = 2'd0;
  localparam logic [1:0] ADDR_RISE_EN = 2'd1;
  localparam logic [1:0] ADDR_FALL_EN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;
  localparam logic [1:0] WARM_DONE    = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] rise_en;
  logic [WIDTH-1:0] fall_en;
  logic [WIDTH-1:0] status;
  logic [1:0]       warm;

  logic             bus_wr;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] clr_mask;

  assign bus_wr = chipSelect & writeEnable;

  // Edges only count once the synchronizer has flushed its reset contents.
  always_comb begin
    edge_set = '0;
    clr_mask = '0;
    if (warm == WARM_DONE) begin
      edge_set = (sync2 & ~prev & rise_en) | (~sync2 & prev & fall_en);
    end
    if (bus_wr && address == ADDR_STATUS) begin
      clr_mask = dataIn[WIDTH-1:0];
    end
  end

  // Synchronizer, warm-up counter and bus-visible registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
      warm    <= '0;
    end else begin
      sync1 <= IO_IN;
      sync2 <= sync1;
      prev  <= sync2;
      if (warm != WARM_DONE) begin
        warm <= warm + 2'd1;
      end
      if (bus_wr && address == ADDR_RISE_EN) begin
        rise_en <= dataIn[WIDTH-1:0];
      end
      if (bus_wr && address == ADDR_FALL_EN) begin
        fall_en <= dataIn[WIDTH-1:0];
      end
      // A new edge in the same cycle as its clear keeps the bit set.
      status <= (status & ~clr_mask) | edge_set;
    end
  end

  always_comb begin
    dataOut = 32'h0;
    if (chipSelect) begin
      case (address)
        ADDR_PIN:     dataOut = 32'(sync2);
        ADDR_RISE_EN: dataOut = 32'(rise_en);
        ADDR_FALL_EN: dataOut = 32'(fall_en);
        ADDR_STATUS:  dataOut = 32'(status);
        default:      dataOut = 32'h0;
      endcase
    end
  end

  assign irq = |status;

endmodule

// File: tb/tb_digital_input_capture.sv
// Scoreboard bench for digital_input_capture: expectations are queued as stimulus
// is applied and checked against bus reads / irq when the queue is drained.
module tb_digital_input_capture;

  localparam logic [1:0] A_PIN  = 2'd0;
  localparam logic [1:0] A_RISE = 2'd1;
  localparam logic [1:0] A_FALL = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        chipSelect;
  logic [1:0]  address;
  logic        writeEnable;
  logic [31:0] dataIn;
  logic [31:0] dataOut;
  logic [31:0] IO_IN;
  logic        irq;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // kind: 0 = selected register read, 1 = irq, 2 = deselected read
  typedef struct {
    string       tag;
    int          kind;
    logic [1:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  digital_input_capture #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .chipSelect  (chipSelect),
    .address     (address),
    .writeEnable (writeEnable),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .IO_IN       (IO_IN),
    .irq         (irq)
  );

  always #10 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipSelect  = 1'b1;
    writeEnable = 1'b1;
    address     = a;
    dataIn      = d;
    tick();
    chipSelect  = 1'b0;
    writeEnable = 1'b0;
    dataIn      = 32'h0;
  endtask

  task automatic exp_reg(input string tag, input logic [1:0] a, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.kind = 0; e.addr = a; e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_irq(input string tag, input logic v);
    exp_t e;
    e.tag = tag; e.kind = 1; e.addr = 2'd0; e.val = {31'h0, v};
    sb.push_back(e);
  endtask

  task automatic exp_desel(input string tag, input logic [1:0] a);
    exp_t e;
    e.tag = tag; e.kind = 2; e.addr = a; e.val = 32'h0;
    sb.push_back(e);
  endtask

  // Reads are combinational, so draining between clock edges leaves state untouched.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      address = e.addr;
      chipSelect = (e.kind == 0);
      #1;
      if (e.kind == 1) check_val(e.tag, {31'h0, irq}, e.val);
      else             check_val(e.tag, dataOut, e.val);
      chipSelect = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; chipSelect = 1'b0; writeEnable = 1'b0;
    address = 2'd0; dataIn = 32'h0; IO_IN = 32'hFFFF_FFFF;

    // Pins high through reset, rise enabled right after release: no false edge.
    repeat (3) tick();
    exp_reg("rst_status", A_STAT, 32'h0);
    exp_reg("rst_rise", A_RISE, 32'h0);
    exp_reg("rst_pin", A_PIN, 32'h0);
    exp_irq("rst_irq", 1'b0);
    exp_desel("rst_desel", A_PIN);
    drain();
    reset = 1'b0;
    bus_write(A_RISE, 32'hFFFF_FFFF);
    repeat (9) tick();
    exp_reg("t1_status", A_STAT, 32'h0);
    exp_irq("t1_irq", 1'b0);
    exp_reg("t1_pin", A_PIN, 32'hFFFF_FFFF);
    exp_reg("t1_rise", A_RISE, 32'hFFFF_FFFF);
    drain();

    // Rising edges with latency: PIN after 2 edges, STATUS after 3.
    bus_write(A_RISE, 32'h0000_FFFF);
    IO_IN = 32'h0;
    repeat (3) tick();
    exp_reg("t2_nofall", A_STAT, 32'h0);
    drain();
    IO_IN = 32'h00FF_00FF;
    tick();
    exp_reg("t2_pin_early", A_PIN, 32'h0);
    drain();
    tick();
    exp_reg("t2_pin", A_PIN, 32'h00FF_00FF);
    exp_reg("t2_stat_early", A_STAT, 32'h0);
    exp_irq("t2_irq_early", 1'b0);
    drain();
    tick();
    exp_reg("t2_status", A_STAT, 32'h0000_00FF);
    exp_irq("t2_irq", 1'b1);
    drain();

    // Enable changes keep STATUS; only enabled edge directions set bits.
    bus_write(A_RISE, 32'h0000_00FF);
    bus_write(A_FALL, 32'hFF00_0000);
    exp_reg("t3_keep", A_STAT, 32'h0000_00FF);
    exp_reg("t3_fall_en", A_FALL, 32'hFF00_0000);
    drain();
    IO_IN = 32'h0000_FFFF;
    repeat (3) tick();
    exp_reg("t3_mixed", A_STAT, 32'h0000_00FF);
    drain();
    IO_IN = 32'h0;
    repeat (3) tick();
    exp_reg("t3_fall_off", A_STAT, 32'h0000_00FF);
    drain();
    IO_IN = 32'hFF00_0000;
    repeat (3) tick();
    exp_reg("t3_rise_off", A_STAT, 32'h0000_00FF);
    drain();
    IO_IN = 32'h0;
    repeat (3) tick();
    exp_reg("t3_fall_on", A_STAT, 32'hFF00_00FF);
    drain();

    // Write-1-to-clear, irq follows the register.
    bus_write(A_STAT, 32'h0000_000F);
    exp_reg("t4_w1c", A_STAT, 32'hFF00_00F0);
    exp_irq("t4_irq_on", 1'b1);
    drain();
    bus_write(A_STAT, 32'hFF00_00F0);
    exp_reg("t4_clear", A_STAT, 32'h0);
    exp_irq("t4_irq_off", 1'b0);
    drain();

    // Set and clear of bit 0 on the same edge: set wins.
    IO_IN = 32'h1;
    tick();
    tick();
    bus_write(A_STAT, 32'h1);
    exp_reg("t5_set_wins", A_STAT, 32'h1);
    exp_irq("t5_irq", 1'b1);
    drain();

    // Deselected reads are zero; PIN ignores writes.
    for (int a = 0; a < 4; a++) exp_desel("t6_desel", 2'(a));
    drain();
    bus_write(A_PIN, 32'hFFFF_FFFF);
    exp_reg("t6_pin_ro", A_PIN, 32'h1);
    drain();

    // Mid-run reset clears everything and restarts warm-up.
    IO_IN = 32'h0;
    reset = 1'b1;
    tick();
    tick();
    exp_reg("t6_rst_stat", A_STAT, 32'h0);
    exp_reg("t6_rst_rise", A_RISE, 32'h0);
    exp_reg("t6_rst_fall", A_FALL, 32'h0);
    exp_irq("t6_rst_irq", 1'b0);
    drain();
    // Bit 0 edge lands on the 3rd clock (blocked), bit 1 on the 4th (allowed).
    reset = 1'b0;
    IO_IN = 32'h1;
    bus_write(A_RISE, 32'h3);
    IO_IN = 32'h3;
    tick();
    tick();
    exp_reg("t6_warm3", A_STAT, 32'h0);
    drain();
    tick();
    exp_reg("t6_warm4", A_STAT, 32'h2);
    exp_irq("t6_warm_irq", 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
